elastic_config_loader: RTL and testbench

- Initiator side of the PE config-load interface.
- Accepts a stream of context entries over the SELF valid/stop handshake and writes them into one ElasticPE's config memory at indices 0..max_id, one entry per write cycle.
- After the last entry is written, pulses start_exec and holds mapping_context_max_id for the run.
- Sits between the CGRA configuration source and each PE's config-load and execution-param ports.

---
 rtl/elastic_config_loader.sv | 161 ++++++++++++++++
 tb/tb_elastic_config_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_config_loader.sv
// Config-load initiator: streams context entries into one PE's config memory
// at indices 0..max_id, then pulses start_exec and holds the max id for the run.
module elastic_config_loader #(
    parameter int unsigned CONTEXT_SIZE               = 8,
    parameter int unsigned CONTEXT_SIZE_BIT_LENGTH    = 3,
    parameter int unsigned NEIGHBOR_PE_NUM            = 4,
    parameter int unsigned NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
    parameter int unsigned OPERATION_BIT_LENGTH       = 4,
    parameter int unsigned DATA_WIDTH                 = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  load_start,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    load_max_id,
    input  logic                                  abort,
    input  logic                                  in_valid,
    output logic                                  in_stop,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_index_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]            in_output_PE_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0]                 in_const_data,
    input  logic                                  in_last,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic                                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic                                  start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
    output logic                                  busy,
    output logic                                  running,
    output logic                                  load_error
);

    // The index field must be able to address every context.
    if (CONTEXT_SIZE > (1 << CONTEXT_SIZE_BIT_LENGTH)) begin : g_bad_size
        $error("CONTEXT_SIZE does not fit in CONTEXT_SIZE_BIT_LENGTH bits");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

    state_e                                state_q, state_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cnt_q, cnt_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    max_id_q, max_id_d;
    logic                                  err_q, err_d;
    logic                                  write_q, write_d;
    logic                                  start_q, start_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    idx_q, idx_d;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [NEIGHBOR_PE_NUM-1:0]            out_q, out_d;
    logic [OPERATION_BIT_LENGTH-1:0]       op_q, op_d;
    logic [DATA_WIDTH-1:0]                 cd_q, cd_d;

    // Next-state: sequencing, entry capture and length checking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_id_d = max_id_q;
        err_d    = err_q;
        write_d  = 1'b0;
        start_d  = 1'b0;
        idx_d    = idx_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        out_d    = out_q;
        op_d     = op_q;
        cd_d     = cd_q;
        if (abort) begin
            // Any coincident transfer or load_start is dropped.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (load_start) begin
                        max_id_d = load_max_id;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        state_d  = StLoad;
                    end
                end
                StLoad: begin
                    // in_stop is low throughout LOAD, so in_valid alone is a transfer.
                    if (in_valid) begin
                        write_d = 1'b1;
                        idx_d   = cnt_q;
                        in1_d   = in_input_PE_index_1;
                        in2_d   = in_input_PE_index_2;
                        out_d   = in_output_PE_index;
                        op_d    = in_op;
                        cd_d    = in_const_data;
                        cnt_d   = cnt_q + 1'b1;
                        if (in_last && (cnt_q == max_id_q)) begin
                            state_d = StStart;
                        end else if (in_last || (cnt_q == max_id_q)) begin
                            // Stream length disagrees with max_id; written entries stay.
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StStart: begin
                    start_d = 1'b1;
                    state_d = StRun;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            max_id_q <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            start_q  <= 1'b0;
            idx_q    <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            out_q    <= '0;
            op_q     <= '0;
            cd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            max_id_q <= max_id_d;
            err_q    <= err_d;
            write_q  <= write_d;
            start_q  <= start_d;
            idx_q    <= idx_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            out_q    <= out_d;
            op_q     <= op_d;
            cd_q     <= cd_d;
        end
    end

    // Outputs decoded from the state register or driven straight from flops.
    always_comb begin
        in_stop                 = (state_q != StLoad);
        busy                    = (state_q == StLoad) || (state_q == StStart);
        running                 = (state_q == StRun);
        write_config_data       = write_q;
        start_exec              = start_q;
        config_index            = idx_q;
        config_input_PE_index_1 = in1_q;
        config_input_PE_index_2 = in2_q;
        config_output_PE_index  = out_q;
        config_op               = op_q;
        config_const_data       = cd_q;
        mapping_context_max_id  = max_id_q;
        load_error              = err_q;
    end

endmodule

// File: tb/tb_elastic_config_loader.sv
// Self-checking bench for elastic_config_loader: table vectors, hand-written
// timing/abort/reset sequences and randomized loads against a transaction model.
module tb_elastic_config_loader;

    typedef struct packed {
        logic [1:0]  i1;
        logic [1:0]  i2;
        logic [3:0]  om;
        logic [3:0]  op;
        logic [31:0] cd;
    } fields_t;

    typedef struct {
        int max_id;
        int n;
        int last_pos;
        int max_gap;
        int exp_w;
        bit exp_err;
        bit exp_start;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic [2:0]  load_max_id = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_stop;
    logic [1:0]  in_input_PE_index_1 = '0;
    logic [1:0]  in_input_PE_index_2 = '0;
    logic [3:0]  in_output_PE_index = '0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_const_data = '0;
    logic        in_last = 1'b0;
    logic [1:0]  config_input_PE_index_1;
    logic [1:0]  config_input_PE_index_2;
    logic [3:0]  config_output_PE_index;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic        write_config_data;
    logic [2:0]  config_index;
    logic        start_exec;
    logic [2:0]  mapping_context_max_id;
    logic        busy;
    logic        running;
    logic        load_error;

    elastic_config_loader dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .load_start              (load_start),
        .load_max_id             (load_max_id),
        .abort                   (abort),
        .in_valid                (in_valid),
        .in_stop                 (in_stop),
        .in_input_PE_index_1     (in_input_PE_index_1),
        .in_input_PE_index_2     (in_input_PE_index_2),
        .in_output_PE_index      (in_output_PE_index),
        .in_op                   (in_op),
        .in_const_data           (in_const_data),
        .in_last                 (in_last),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_output_PE_index  (config_output_PE_index),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .config_index            (config_index),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .busy                    (busy),
        .running                 (running),
        .load_error              (load_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [46:0] obs_q[$];
    int          wcyc_q[$];
    int          start_cnt = 0;
    int          start_cyc = -1;
    fields_t     ents[16];
    bit          lasts[16];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/start monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (write_config_data) begin
            obs_q.push_back({config_index, config_input_PE_index_1, config_input_PE_index_2,
                             config_output_PE_index, config_op, config_const_data});
            wcyc_q.push_back(cyc);
        end
        if (start_exec) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int i);
        in_input_PE_index_1 = ents[i].i1;
        in_input_PE_index_2 = ents[i].i2;
        in_output_PE_index  = ents[i].om;
        in_op               = ents[i].op;
        in_const_data       = ents[i].cd;
        in_last             = lasts[i];
    endtask

    // Entry at which a load with this max_id terminates (last flag or count reached).
    function automatic int end_index(input int max_id);
        for (int i = 0; i < 16; i++) begin
            if (lasts[i] || i == max_id) return i;
        end
        return max_id;
    endfunction

    // Start a load and feed entries until the model says the load ends.
    task automatic run_load(input int max_id, input int n, input int max_gap);
        int  k;
        bit  acc;
        int  w;
        int  g;
        k = end_index(max_id);
        load_start  = 1'b1;
        load_max_id = 3'(max_id);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) tick();
            apply(i);
            in_valid = 1'b1;
            acc = 1'b0;
            w = 0;
            while (!acc && w < 20) begin
                @(negedge clk);
                acc = !in_stop;
                tick();
                w++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!acc) begin
                chk("entry_accept_timeout", 64'(i), 64'hFFFF);
                break;
            end
            if (i == k) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_load(input string tag, input int max_id, input int exp_w,
                              input bit exp_err, input bit exp_start, input bit b2b,
                              input int base_w, input int base_s);
        int          nw;
        logic [2:0]  kk;
        nw = obs_q.size() - base_w;
        chk({tag, "_nwrites"}, 64'(nw), 64'(exp_w));
        for (int k = 0; k < exp_w && k < nw; k++) begin
            kk = k[2:0];
            chk({tag, "_write"}, 64'(obs_q[base_w + k]), 64'({kk, ents[k]}));
            if (b2b && k > 0)
                chk({tag, "_b2b"}, 64'(wcyc_q[base_w + k] - wcyc_q[base_w + k - 1]), 64'd1);
        end
        chk({tag, "_starts"}, 64'(start_cnt - base_s), 64'(exp_start));
        if (exp_start && nw > 0)
            chk({tag, "_start_lat"}, 64'(start_cyc - wcyc_q[obs_q.size() - 1]), 64'd1);
        chk({tag, "_err"}, 64'(load_error), 64'(exp_err));
        chk({tag, "_running"}, 64'(running), 64'(exp_start));
        chk({tag, "_maxid"}, 64'(mapping_context_max_id), 64'(max_id));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_stop"}, 64'(in_stop), 64'd1);
    endtask

    task automatic fill_table_ents(input int last_pos);
        for (int i = 0; i < 16; i++) begin
            ents[i].i1 = 2'(i % 4);
            ents[i].i2 = 2'((i + 1) % 4);
            ents[i].om = 4'(1 << (i % 4));
            ents[i].op = 4'(2 * i + 1);
            ents[i].cd = 32'(10 * (i + 1));
            lasts[i]   = (i == last_pos);
        end
    endtask

    vec_t tbl[7];

    initial begin
        int vt[7];
        int e;
        int bw;
        int bs;
        int mx;
        int k;

        tbl[0] = '{2, 3,  2, 0, 3, 1'b0, 1'b1};
        tbl[1] = '{3, 4,  1, 2, 2, 1'b1, 1'b0};
        tbl[2] = '{3, 4,  3, 2, 4, 1'b0, 1'b1};
        tbl[3] = '{1, 2, -1, 1, 2, 1'b1, 1'b0};
        tbl[4] = '{7, 8,  7, 0, 8, 1'b0, 1'b1};
        tbl[5] = '{0, 1,  0, 0, 1, 1'b0, 1'b1};
        tbl[6] = '{5, 6,  0, 1, 1, 1'b1, 1'b0};

        // Reset state.
        repeat (2) tick();
        @(negedge clk);
        chk("rst_stop", 64'(in_stop), 64'd1);
        chk("rst_write", 64'(write_config_data), 64'd0);
        chk("rst_start", 64'(start_exec), 64'd0);
        chk("rst_busy", 64'(busy | running | load_error), 64'd0);
        chk("rst_maxid", 64'(mapping_context_max_id), 64'd0);
        chk("rst_cfg", 64'({config_index, config_op, config_const_data}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reset mid-LOAD for two cycles.
        fill_table_ents(-1);
        load_start = 1'b1;
        load_max_id = 3'd5;
        tick();
        load_start = 1'b0;
        apply(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("midrst_stop", 64'(in_stop), 64'd1);
        chk("midrst_write", 64'(write_config_data), 64'd0);
        chk("midrst_start", 64'(start_exec), 64'd0);
        chk("midrst_maxid", 64'(mapping_context_max_id), 64'd0);
        chk("midrst_state", 64'({busy, running}), 64'd0);
        reset_n = 1'b1;
        tick();

        // Table vectors.
        for (int t = 0; t < 7; t++) begin
            fill_table_ents(tbl[t].last_pos);
            bw = obs_q.size();
            bs = start_cnt;
            run_load(tbl[t].max_id, tbl[t].n, tbl[t].max_gap);
            check_load($sformatf("vec%0d", t), tbl[t].max_id, tbl[t].exp_w, tbl[t].exp_err,
                       tbl[t].exp_start, tbl[t].max_gap == 0, bw, bs);
        end

        // abort with load_start in IDLE: abort wins, error stays sticky.
        abort = 1'b1;
        load_start = 1'b1;
        load_max_id = 3'd4;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ls_busy", 64'(busy), 64'd0);
        chk("abort_ls_err", 64'(load_error), 64'd1);
        chk("abort_ls_maxid", 64'(mapping_context_max_id), 64'd5);
        abort = 1'b0;
        load_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ls_idle", 64'({busy, in_stop}), 64'b01);

        // abort coinciding with the idx-1 transfer.
        fill_table_ents(-1);
        load_start = 1'b1;
        load_max_id = 3'd3;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        chk("abort_tx_load", 64'({busy, load_error}), 64'b10);
        apply(0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx_w0", 64'({write_config_data, config_index}), 64'({1'b1, 3'd0}));
        apply(1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_tx_nowrite", 64'(write_config_data), 64'd0);
        chk("abort_tx_state", 64'({busy, in_stop, start_exec}), 64'b010);
        chk("abort_tx_idx", 64'(config_index), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_tx_idle", 64'({write_config_data, busy}), 64'd0);

        // Valid toggling 1,0,0,1,1,0,1 with max_id 3; config holds through gaps.
        for (int i = 0; i < 16; i++) begin
            ents[i] = '{i1: 2'(3 - i % 4), i2: 2'(i % 4), om: 4'(15 - i),
                        op: 4'(i + 5), cd: 32'(100 + i)};
            lasts[i] = (i == 3);
        end
        vt = '{1, 0, 0, 1, 1, 0, 1};
        load_start = 1'b1;
        load_max_id = 3'd3;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        e = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = vt[c][0];
            if (vt[c] != 0) apply(e);
            @(posedge clk);
            @(negedge clk);
            chk("tog_write", 64'(write_config_data), 64'(vt[c]));
            if (vt[c] != 0) begin
                chk("tog_entry", 64'({config_index, config_input_PE_index_1,
                                      config_input_PE_index_2, config_output_PE_index,
                                      config_op, config_const_data}),
                    64'({e[2:0], ents[e]}));
                e++;
            end else begin
                chk("tog_hold", 64'({config_op, config_const_data}),
                    64'({ents[e - 1].op, ents[e - 1].cd}));
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tog_start", 64'({start_exec, running, write_config_data}), 64'b110);
        @(posedge clk);
        @(negedge clk);
        chk("tog_start_once", 64'(start_exec), 64'd0);

        // Randomized loads against the transaction model.
        for (int r = 0; r < 30; r++) begin
            mx = int'($urandom_range(7, 0));
            for (int i = 0; i < 16; i++) begin
                ents[i] = fields_t'({$urandom, $urandom});
                lasts[i] = ($urandom_range(5, 0) == 0);
            end
            if ($urandom_range(1, 0) == 1) lasts[mx] = 1'b1;
            k = end_index(mx);
            bw = obs_q.size();
            bs = start_cnt;
            run_load(mx, 9, 2);
            check_load($sformatf("rnd%0d", r), mx, k + 1, !(lasts[k] && k == mx),
                       lasts[k] && k == mx, 1'b0, bw, bs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
